// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: two combinational read ports, one write port
// and a scoreboard allocation port.
//
// Handshake semantics: there is no per-transfer valid/ready pairing on this
// bus. `ready` is a level status from the register file. While it is low,
// every request (we, alloc_en) is dropped and reads return zero. While it is
// high, a request presented with we/alloc_en high is taken at that rising
// clock edge, unconditionally and with no back-pressure.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            ready;
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            busy1;
  logic            busy2;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            alloc_en;
  logic [AW-1:0]   alloc_addr;

  // Requester side: drives addresses, write data and allocations.
  modport master (
    input  ready, rd1, rd2, busy1, busy2,
    output ra1, ra2, we, wa, wd, alloc_en, alloc_addr
  );

  // Register-file side.
  modport slave (
    output ready, rd1, rd2, busy1, busy2,
    input  ra1, ra2, we, wa, wd, alloc_en, alloc_addr
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: register file with a pending-write scoreboard.
// Register 0 is hardwired to zero. After reset, an INIT phase clears one
// register per cycle. Once that phase ends, `ready` goes high and both
// ports become live.
// Compile-time option: define REGFILE_BYPASS_EN to make a same-cycle write
// visible on a read port whose address matches the write address
// (write-through). It does not change FSM timing, scoreboard behaviour or
// ready.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  regfile_sb_if.slave   bus,
  output logic          o_dbg_state   // 0 = INIT, 1 = RUN
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_ptr;
  logic [AW-1:0]   w_clr_ptr_nxt;
  logic            w_clr_en;
  logic            w_run;

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic            w_wr_en;
  logic            w_alloc_en;
  logic            w_byp1;
  logic            w_byp2;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  // State and clear-pointer register; reset restarts the full clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // Next-state logic: sweep clr_ptr over every register, then enter RUN.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_clr_en      = 1'b0;
    w_run         = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clr_en      = 1'b1;
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == AW'(NREGS - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Requests count only in RUN and never target register 0.
  assign w_wr_en    = w_run & bus.we       & (bus.wa != '0);
  assign w_alloc_en = w_run & bus.alloc_en & (bus.alloc_addr != '0);

  // Register array write: INIT clears, RUN writes. Reset itself leaves the
  // contents alone, because the INIT sweep that follows overwrites them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_en) begin
        r_regs[r_clr_ptr] <= '0;
      end else if (w_wr_en) begin
        r_regs[bus.wa] <= bus.wd;
      end
    end
  end

  // Scoreboard bits: a write clears its destination, and an alloc sets it.
  // The alloc is applied last so that it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else if (!w_run) begin
      r_busy <= '0;
    end else begin
      if (w_wr_en) begin
        r_busy[bus.wa] <= 1'b0;
      end
      if (w_alloc_en) begin
        r_busy[bus.alloc_addr] <= 1'b1;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Write-through select: forward wd to a port reading the address being written.
  always_comb begin
    w_byp1 = w_wr_en & (bus.ra1 == bus.wa);
    w_byp2 = w_wr_en & (bus.ra2 == bus.wa);
  end
`else
  // No write-through: reads always see the stored (pre-write) value.
  always_comb begin
    w_byp1 = 1'b0;
    w_byp2 = 1'b0;
  end
`endif

  // Combinational read ports: zero in INIT and for register 0.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_run && (bus.ra1 != '0)) begin
      w_rd1 = w_byp1 ? bus.wd : r_regs[bus.ra1];
    end
    if (w_run && (bus.ra2 != '0)) begin
      w_rd2 = w_byp2 ? bus.wd : r_regs[bus.ra2];
    end
  end

  assign bus.rd1     = w_rd1;
  assign bus.rd2     = w_rd2;
  // Registered scoreboard view only; bit 0 is never set.
  assign bus.busy1   = w_run & r_busy[bus.ra1];
  assign bus.busy2   = w_run & r_busy[bus.ra2];
  assign bus.ready   = w_run;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: init sweep, INIT gating, a table of single-cycle RUN
// vectors (reads, writes, bypass, scoreboard), then reset in the middle of RUN.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  logic dbg_state;
  int   n_pass;
  int   n_total;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            al;
    logic [AW-1:0]   aa;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] e_rd1;
    logic [XLEN-1:0] e_rd2;
    logic            e_b1;
    logic            e_b2;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(logic we, logic [AW-1:0] wa, logic [XLEN-1:0] wd,
                              logic al, logic [AW-1:0] aa,
                              logic [AW-1:0] ra1, logic [AW-1:0] ra2,
                              logic [XLEN-1:0] e_rd1, logic [XLEN-1:0] e_rd2,
                              logic e_b1, logic e_b2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.al = al; v.aa = aa;
    v.ra1 = ra1; v.ra2 = ra2;
    v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_b1 = e_b1; v.e_b2 = e_b2;
    return v;
  endfunction

  task automatic check(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
    bus.alloc_en = 1'b0; bus.alloc_addr = '0;
  endtask

  // Called at a negedge right after rst has been sampled high for the last
  // time. Counts the negedges on which ready is still low and drops any
  // gating stimulus as soon as ready is seen high.
  task automatic wait_ready(string name);
    int cyc;
    cyc = 0;
    #1;
    check({name, "_init_rd1"},   bus.rd1, '0);
    check({name, "_init_busy1"}, {31'b0, bus.busy1}, '0);
    while (!bus.ready && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    drive_idle();
    check({name, "_ready_cycles"}, cyc, NREGS);
    check({name, "_dbg_run"}, {31'b0, dbg_state}, 32'd1);
  endtask

  task automatic check_all_zero(string name);
    for (int i = 0; i < NREGS; i++) begin
      @(negedge clk);
      bus.ra1 = AW'(i);
      bus.ra2 = AW'(NREGS - 1 - i);
      #1;
      check($sformatf("%s_rd1_r%0d", name, i), bus.rd1, '0);
      check($sformatf("%s_rd2_r%0d", name, NREGS - 1 - i), bus.rd2, '0);
      check($sformatf("%s_busy_r%0d", name, i), {31'b0, bus.busy1}, '0);
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1;
    drive_idle();
    bus.ra1 = 5'd4;
    bus.ra2 = 5'd4;

    // Single-cycle RUN vectors; expected values are the pre-edge outputs.
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0,  5, 0,  BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0);
    vt[1]  = mk(1, 0, 32'h1,        0, 0,  5, 0,  32'hDEADBEEF, 0, 0, 0);
    vt[2]  = mk(0, 0, 0,            0, 0,  0, 5,  0, 32'hDEADBEEF, 0, 0);
    vt[3]  = mk(1, 7, 32'h12345678, 0, 0,  5, 7,  32'hDEADBEEF, BYP ? 32'h12345678 : 32'h0, 0, 0);
    vt[4]  = mk(1, 7, 32'hA5A5A5A5, 0, 0,  7, 7,  BYP ? 32'hA5A5A5A5 : 32'h12345678,
                                                  BYP ? 32'hA5A5A5A5 : 32'h12345678, 0, 0);
    vt[5]  = mk(0, 0, 0,            1, 9,  9, 7,  0, 32'hA5A5A5A5, 0, 0);
    vt[6]  = mk(0, 0, 0,            0, 0,  9, 9,  0, 0, 1, 1);
    vt[7]  = mk(1, 9, 32'h99,       0, 0,  9, 0,  BYP ? 32'h99 : 32'h0, 0, 1, 0);
    vt[8]  = mk(0, 0, 0,            0, 0,  9, 0,  32'h99, 0, 0, 0);
    vt[9]  = mk(1, 9, 32'h1234,     1, 9,  9, 0,  BYP ? 32'h1234 : 32'h99, 0, 0, 0);
    vt[10] = mk(0, 0, 0,            0, 0,  9, 0,  32'h1234, 0, 1, 0);
    vt[11] = mk(0, 0, 0,            1, 0,  0, 9,  0, 32'h1234, 0, 1);
    vt[12] = mk(0, 0, 0,            1, 3,  0, 9,  0, 32'h1234, 0, 1);
    vt[13] = mk(1, 31, 32'hFFFFFFFF, 0, 0, 3, 31, 0, BYP ? 32'hFFFFFFFF : 32'h0, 1, 0);
    vt[14] = mk(0, 0, 0,            0, 0,  31, 3, 32'hFFFFFFFF, 0, 0, 1);
    vt[15] = mk(0, 0, 0,            0, 0,  7, 9,  32'hA5A5A5A5, 32'h1234, 0, 1);

    // Reset, then INIT with write/alloc to register 4 held active (must be ignored).
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, bus.ready}, '0);
    check("rst_dbg_init", {31'b0, dbg_state}, '0);
    rst = 1'b0;
    bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'hFF;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd4;
    wait_ready("init");
    check_all_zero("init");

    // Table-driven RUN vectors.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.we = vt[i].we; bus.wa = vt[i].wa; bus.wd = vt[i].wd;
      bus.alloc_en = vt[i].al; bus.alloc_addr = vt[i].aa;
      bus.ra1 = vt[i].ra1; bus.ra2 = vt[i].ra2;
      #1;
      check($sformatf("vec%0d_rd1", i),   bus.rd1, vt[i].e_rd1);
      check($sformatf("vec%0d_rd2", i),   bus.rd2, vt[i].e_rd2);
      check($sformatf("vec%0d_busy1", i), {31'b0, bus.busy1}, {31'b0, vt[i].e_b1});
      check($sformatf("vec%0d_busy2", i), {31'b0, bus.busy2}, {31'b0, vt[i].e_b2});
    end

    // Reset in the middle of RUN; the write/alloc in the reset cycle is discarded.
    @(negedge clk);
    rst = 1'b1;
    bus.ra1 = 5'd3; bus.ra2 = 5'd31;
    bus.we = 1'b1; bus.wa = 5'd6; bus.wd = 32'h66;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd6;
    @(negedge clk);
    drive_idle();
    check("midrst_ready", {31'b0, bus.ready}, '0);
    check("midrst_busy3", {31'b0, bus.busy1}, '0);
    check("midrst_rd31",  bus.rd2, '0);
    rst = 1'b0;
    wait_ready("midrst");
    check_all_zero("midrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data width in bits.
REQ-002 SHALL provide parameter NREGS, default 32, register count (power of two, >=2).
REQ-003 SHALL provide parameter AW, default $clog2(NREGS), register address width.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ready  output  1  high when init-clear is done and ports are live.
REQ-007 ra1, ra2  input  AW each  read addresses.
REQ-008 rd1, rd2  output  XLEN each  read data.
REQ-009 busy1, busy2  output  1 each  scoreboard pending bit for ra1/ra2.
REQ-010 we  input  1  write enable; wa  input  AW  write address; wd  input  XLEN  write data.
REQ-011 alloc_en  input  1  mark destination pending; alloc_addr  input  AW  destination address.

Function
REQ-012 SHALL implement a two-state FSM: INIT and RUN.
REQ-013 INIT: clears one register per cycle at clr_ptr (0..NREGS-1), increments clr_ptr; moves to RUN on the cycle after clearing NREGS-1.
REQ-014 ready SHALL be 0 in INIT and 1 in RUN; it rises exactly NREGS cycles after the first clk edge with rst low.
REQ-015 In INIT, we and alloc_en SHALL be ignored; rd1/rd2 SHALL read 0 and busy1/busy2 SHALL read 0.
REQ-016 Reads SHALL be combinational: rdN = registers[raN], with zero latency.
REQ-017 In RUN, a write with we=1 and wa!=0 SHALL update registers[wa] at the clk edge.
REQ-018 Register 0 SHALL always read 0; writes and allocs to address 0 SHALL be ignored; busy for address 0 SHALL always read 0.
REQ-019 In RUN, alloc_en=1 SHALL set busy[alloc_addr] at the clk edge.
REQ-020 In RUN, we=1 SHALL clear busy[wa] at the clk edge.
REQ-021 If alloc_en and we target the same nonzero address in the same cycle, busy SHALL end set (alloc wins) and the data SHALL still be written.
REQ-022 busy1/busy2 SHALL reflect the registered busy bits only; a same-cycle write SHALL NOT clear them combinationally.
REQ-023 Simultaneous reads of the same address on both ports SHALL return identical data.

Reset
REQ-024 rst=1 at a clk edge SHALL force state INIT, clr_ptr=0, all busy bits 0, and ready=0.
REQ-025 rst SHALL NOT reset register contents directly; INIT clears them after rst falls.
REQ-026 rst asserted mid-INIT or mid-RUN SHALL restart the full NREGS-cycle clear, discarding any same-cycle write or alloc.

Configuration
REQ-027 The macro REGFILE_BYPASS_EN SHALL select write-through bypass at compile time.
REQ-028 With REGFILE_BYPASS_EN defined, in RUN with we=1, wa!=0 and raN==wa, rdN SHALL return wd in the same cycle.
REQ-029 Without REGFILE_BYPASS_EN, rdN SHALL return the stored (pre-write) value in that cycle.
REQ-030 The macro SHALL NOT affect FSM timing, scoreboard behaviour, or ready.

Verification
REQ-031 Init: pulse rst for 1 cycle with NREGS=32, then hold rst low -> ready=0 for 32 cycles then 1; every register reads 0.
REQ-032 Write/read: in RUN, write wa=5, wd=0xDEADBEEF -> the next cycle rd1 with ra1=5 reads 0xDEADBEEF; write to wa=0 with 0x1 -> ra1=0 reads 0.
REQ-033 Bypass: we=1, wa=7, wd=0x12345678 with ra2=7 in the same cycle -> rd2=0x12345678 with the macro defined, and the old value without it.
REQ-034 Scoreboard: alloc_en with addr 9 -> busy1=1 for ra1=9 the next cycle; then we=1, wa=9 -> busy1=0 after that edge; alloc and write to 9 in one cycle -> busy1 stays 1 and the data is updated.
REQ-035 Reset mid-RUN: registers hold nonzero data with busy[3]=1; assert rst -> busy clears and ready drops; after NREGS cycles all reads are 0 and ready=1.
REQ-036 INIT gating: drive we=1, wa=4, wd=0xFF and alloc_en to addr 4 during INIT -> after ready rises, register 4 reads 0 and busy for 4 reads 0.
